// File: rtl/instruction_fetch_pkg.sv
// Shared front-end pipeline definitions: the SPARC NOP bubble word and the
// fetch FSM state type.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h0100_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding word request to instruction memory,
// presents the fetched word plus its PC+4 to decode, redirects squash fetch.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned                BUS_DATA_WIDTH = 64,
    parameter int unsigned                BUS_INST_WIDTH = 32,
    parameter logic [BUS_DATA_WIDTH-1:0]  RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_ready,
    input  logic                      redirect_en,
    input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
    output logic                      imem_req,
    output logic [BUS_DATA_WIDTH-1:0] imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [BUS_INST_WIDTH-1:0] imem_rdata,
    output logic [BUS_INST_WIDTH-1:0] inst,
    output logic [BUS_DATA_WIDTH-1:0] IF_PCplus4_out,
    output logic [BUS_DATA_WIDTH-1:0] fetch_pc_out
);

    localparam logic [BUS_DATA_WIDTH-1:0] PC_ALIGN_MASK = ~BUS_DATA_WIDTH'(3);
    localparam logic [BUS_DATA_WIDTH-1:0] PC_STEP       = BUS_DATA_WIDTH'(4);

    fetch_state_e              state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic [BUS_INST_WIDTH-1:0] inst_q, inst_d;
    logic                      kill_q, kill_d;
    logic                      offer_valid;

    // A redirect masks the held word in the same cycle so decode never takes it.
    assign offer_valid    = (state_q == HOLD) && !redirect_en;
    assign imem_req       = (state_q == REQ) && !reset;
    assign imem_addr      = pc_q;
    assign inst           = offer_valid ? inst_q : BUS_INST_WIDTH'(NOP_INST);
    assign IF_PCplus4_out = offer_valid ? pc4_q : '0;
    assign fetch_pc_out   = pc_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        kill_d  = kill_q;

        case (state_q)
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                    kill_d  = redirect_en;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q || redirect_en) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        inst_d  = imem_rdata;
                        pc4_d   = pc_q + PC_STEP;
                        pc_d    = pc_q + PC_STEP;
                        state_d = HOLD;
                    end
                end else if (redirect_en) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_en || id_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        if (redirect_en) begin
            pc_d = redirect_pc & PC_ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            inst_q  <= BUS_INST_WIDTH'(NOP_INST);
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
        end
    end

    // Memory may only answer while a request is outstanding.
    rvalid_only_in_wait: assert property (
        @(posedge clk) disable iff (reset) imem_rvalid |-> (state_q == WAIT)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a latency-randomized memory, random
// decode back-pressure and redirects, checked against an instruction-stream model.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam logic [31:0] NOP    = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ready;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [63:0] IF_PCplus4_out;
    logic [63:0] fetch_pc_out;

    int checks = 0;
    int errors = 0;

    instruction_fetch #(
        .BUS_DATA_WIDTH(64),
        .BUS_INST_WIDTH(32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_ready(id_ready),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .inst(inst),
        .IF_PCplus4_out(IF_PCplus4_out),
        .fetch_pc_out(fetch_pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory image: address-dependent and never equal to the NOP bubble.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = a[31:0] ^ a[63:32] ^ 32'h5A5A_0000 ^ {a[9:2], 24'h0};
        w[31] = 1'b1;
        return w;
    endfunction

    logic [63:0] exp_pc;
    logic        mem_busy;
    logic [63:0] mem_addr;
    int          mem_cnt;
    logic        prev_held;
    logic [31:0] prev_inst;
    logic [63:0] prev_pc4;
    int          transfers;
    int          wraps;

    initial begin
        reset       = 1'b1;
        id_ready    = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        exp_pc      = RST_PC;
        mem_busy    = 1'b0;
        mem_addr    = '0;
        mem_cnt     = 0;
        prev_held   = 1'b0;
        prev_inst   = '0;
        prev_pc4    = '0;
        transfers   = 0;
        wraps       = 0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_imem_req", 64'(imem_req), 64'd0);
        check("rst_inst", 64'(inst), 64'(NOP));
        check("rst_pc4", IF_PCplus4_out, 64'd0);
        check("rst_fetch_pc", fetch_pc_out, RST_PC);
        reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            id_ready    = ($urandom_range(0, 2) != 0);
            redirect_en = (cyc > 20) && ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = 64'h2003;
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFF7 + 64'($urandom_range(0, 4));
                default: redirect_pc = {$urandom, $urandom};
            endcase
            imem_rvalid = 1'b0;
            if (mem_busy) begin
                mem_cnt--;
                imem_rvalid = (mem_cnt == 0);
            end
            imem_rdata = imem_rvalid ? mem_word(mem_addr) : $urandom;
            imem_gnt   = !mem_busy && ($urandom_range(0, 2) != 0);
            #1;

            if (mem_busy) check("single_outstanding", 64'(imem_req), 64'd0);
            if (prev_held) check("no_req_in_hold", 64'(imem_req), 64'd0);
            if (prev_held && !redirect_en) begin
                check("hold_inst_stable", 64'(inst), 64'(prev_inst));
                check("hold_pc4_stable", IF_PCplus4_out, prev_pc4);
            end
            if (imem_req && imem_gnt) check("req_addr", imem_addr, exp_pc);

            if (redirect_en) begin
                check("nop_on_redirect", 64'(inst), 64'(NOP));
            end else if (inst != NOP) begin
                check("inst_word", 64'(inst), 64'(mem_word(exp_pc)));
                check("inst_pc4", IF_PCplus4_out, exp_pc + 64'd4);
                if (id_ready) begin
                    if (exp_pc == 64'hFFFF_FFFF_FFFF_FFFC) wraps++;
                    exp_pc = exp_pc + 64'd4;
                    transfers++;
                end
            end
            if (inst == NOP) check("pc4_zero_with_nop", IF_PCplus4_out, 64'd0);

            if (redirect_en) exp_pc = redirect_pc & ~64'd3;

            prev_held = (inst != NOP) && !id_ready && !redirect_en;
            prev_inst = inst;
            prev_pc4  = IF_PCplus4_out;

            if (imem_rvalid) mem_busy = 1'b0;
            if (imem_req && imem_gnt) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(1, 3);
            end
        end

        check("enough_transfers", 64'(transfers >= 300), 64'd1);
        check("wrap_seen", 64'(wraps > 0), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front pipeline stage that produces the instruction stream consumed by instruction decode. It holds the architectural fetch PC and issues one word request at a time to instruction memory. It presents each fetched word, together with its PC+4, to decode under the id_ready handshake. When decode has nothing valid to take, the stage drives the SPARC NOP (32'h01000000). Branch and trap redirects from later stages override sequential fetch and squash any in-flight or held word.

Parameters:
BUS_DATA_WIDTH, 64, width of PC, PC+4 and memory address
BUS_INST_WIDTH, 32, instruction word width
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_ready  in  1  decode accepts inst/IF_PCplus4_out this cycle
redirect_en  in  1  load redirect_pc and squash in-flight/held fetch
redirect_pc  in  BUS_DATA_WIDTH  new fetch PC; bits [1:0] ignored (forced 0)
imem_req  out  1  request valid
imem_addr  out  BUS_DATA_WIDTH  word-aligned request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  BUS_INST_WIDTH  response word
inst  out  BUS_INST_WIDTH  instruction to decode; NOP when no valid word
IF_PCplus4_out  out  BUS_DATA_WIDTH  PC+4 of the presented inst; 0 with NOP
fetch_pc_out  out  BUS_DATA_WIDTH  current fetch PC (debug/trap save)

Behaviour:
- Reset values: pc=RESET_PC, state=REQ, kill=0, imem_req=0 while reset is asserted, inst=NOP, IF_PCplus4_out=0, fetch_pc_out=RESET_PC.
- States:
  - REQ: issue a request.
  - WAIT: request granted; awaiting rvalid.
  - HOLD: word latched; offering it to decode.
- REQ: imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT.
  - imem_gnt=0 -> stay in REQ; imem_addr remains stable.
- WAIT: imem_req=0.
  - imem_rvalid=1 and kill=0: latch inst_q=imem_rdata and pc4_q=pc+4; pc<=pc+4; -> HOLD.
  - imem_rvalid=1 and kill=1: discard the word, clear kill -> REQ.
- HOLD: inst=inst_q, IF_PCplus4_out=pc4_q, imem_req=0.
  - id_ready=1: transfer completes this cycle -> REQ.
  - id_ready=0: stay in HOLD; outputs remain stable.
- Outside HOLD: inst=NOP and IF_PCplus4_out=0, regardless of id_ready.
- Redirect (highest priority, every state):
  - pc<=redirect_pc with bits [1:0]=0.
  - inst is driven NOP combinationally in the redirect cycle, so no transfer occurs even if id_ready=1.
  - REQ without gnt: stay in REQ; the next cycle requests the new pc.
  - REQ with gnt in the same cycle: the old-pc request is in flight -> WAIT with kill=1.
  - WAIT: kill<=1 and stay in WAIT. If rvalid arrives in the same cycle, drop the word -> REQ with kill=0.
  - HOLD: drop the held word -> REQ.
- Back-to-back redirects: the last one wins; kill stays set until the stale response returns.
- Exactly one outstanding request at a time. Peak throughput is one instruction per 3 cycles with a 1-cycle memory.
- PC arithmetic: unsigned, modulo 2^BUS_DATA_WIDTH; wrap from all-ones-minus-3 to 0 is legal.
- imem_rvalid while in REQ or HOLD: protocol violation; ignore it and flag with an assertion.
- Reset mid-transaction: all state clears asynchronously. The first response after deassertion is not expected; memory must be reset together with this block.

Decomposition:
- Shared pipeline package holds:
  - NOP constant 32'h01000000, shared with decode's bubble detection.
  - fetch_state_e enum {REQ, WAIT, HOLD}.
- No sub-module; a single always_ff/always_comb pair. PC-increment logic is inline.

Test Plan:
1. Reset, RESET_PC=0x100, memory returns 0x8210_0001 one cycle after gnt, id_ready=1 -> imem_addr=0x100; inst=0x82100001 and IF_PCplus4_out=0x104 for one cycle; next request addr 0x104.
2. id_ready held 0 for 5 cycles during HOLD -> inst and IF_PCplus4_out stable for 5 cycles, no new imem_req; transfer when id_ready rises.
3. redirect_en with redirect_pc=0x2003 during WAIT, stale rvalid data 0xDEAD_BEEF two cycles later -> stale word never appears (inst=NOP); next imem_addr=0x2000.
4. redirect_en and imem_gnt in the same REQ cycle -> kill set; first response dropped; second request addr=redirect_pc.
5. redirect_en during HOLD with id_ready=1 -> inst=NOP that cycle, held word discarded; next request at the new PC.
6. PC=0xFFFF_FFFF_FFFF_FFFC fetch completes -> IF_PCplus4_out=0, next imem_addr=0.
